// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command host: opcodes, command and state encodings,
// and per-command frame/response counts.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_ALU   = 2'b10,
        OP_NOP   = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SEND     = 2'b01,
        WAIT_RSP = 2'b10,
        DONE     = 2'b11
    } host_state_t;

    localparam logic [7:0] OPC_WRITE = 8'hAA;
    localparam logic [7:0] OPC_READ  = 8'hBB;
    localparam logic [7:0] OPC_ALU   = 8'hCC;
    localparam logic [7:0] OPC_NOP   = 8'hDD;

    function automatic logic [2:0] frame_count(input cmd_op_t op);
        case (op)
            OP_WRITE: frame_count = 3'd3;
            OP_READ:  frame_count = 3'd2;
            OP_ALU:   frame_count = 3'd4;
            OP_NOP:   frame_count = 3'd2;
            default:  frame_count = 3'd2;
        endcase
    endfunction

    function automatic logic [1:0] rsp_count(input cmd_op_t op);
        case (op)
            OP_WRITE: rsp_count = 2'd0;
            OP_READ:  rsp_count = 2'd1;
            OP_ALU:   rsp_count = 2'd2;
            OP_NOP:   rsp_count = 2'd2;
            default:  rsp_count = 2'd0;
        endcase
    endfunction

    // Byte at position idx of the outgoing frame for a given command.
    function automatic logic [7:0] frame_byte(input cmd_op_t op, input logic [1:0] idx,
                                              input logic [3:0] addr, input logic [7:0] data,
                                              input logic [7:0] opb, input logic [3:0] fun);
        logic [7:0] b;
        b = 8'h00;
        case (op)
            OP_WRITE: case (idx)
                2'd0:    b = OPC_WRITE;
                2'd1:    b = {4'h0, addr};
                2'd2:    b = data;
                default: b = 8'h00;
            endcase
            OP_READ: case (idx)
                2'd0:    b = OPC_READ;
                2'd1:    b = {4'h0, addr};
                default: b = 8'h00;
            endcase
            OP_ALU: case (idx)
                2'd0:    b = OPC_ALU;
                2'd1:    b = data;
                2'd2:    b = opb;
                2'd3:    b = {4'h0, fun};
                default: b = 8'h00;
            endcase
            OP_NOP: case (idx)
                2'd0:    b = OPC_NOP;
                2'd1:    b = {4'h0, fun};
                default: b = 8'h00;
            endcase
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_cmd_host.sv
// Serialises register-file / ALU commands into UART byte frames and collects the reply.
// Optional response timeout enabled by defining CMD_HOST_TIMEOUT_EN.
module uart_cmd_host
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    input  logic [7:0]  cmd_opb,
    input  logic [3:0]  cmd_fun,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    host_state_t state_r;
    cmd_op_t     op_r;
    logic [3:0]  addr_r;
    logic [7:0]  data_r;
    logic [7:0]  opb_r;
    logic [3:0]  fun_r;
    logic [1:0]  frame_idx_r;
    logic [1:0]  rx_cnt_r;
    logic [7:0]  rx_lo_r;
    logic        last_frame_s;
    logic        last_rx_s;

    assign last_frame_s = ({1'b0, frame_idx_r} == (frame_count(op_r) - 3'd1));
    assign last_rx_s    = ((rx_cnt_r + 2'd1) == rsp_count(op_r));

`ifdef CMD_HOST_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt_r;
    logic             rsp_err_r;

    // Response-wait counter: runs only while waiting, zero on every entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == WAIT_RSP) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign rsp_err = rsp_err_r;
`else
    assign rsp_err = 1'b0;
`endif

    // Command FSM with registered handshake, frame and response outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            op_r        <= OP_WRITE;
            addr_r      <= 4'h0;
            data_r      <= 8'h00;
            opb_r       <= 8'h00;
            fun_r       <= 4'h0;
            frame_idx_r <= 2'd0;
            rx_cnt_r    <= 2'd0;
            rx_lo_r     <= 8'h00;
            cmd_ready   <= 1'b1;
            tx_byte     <= 8'h00;
            tx_valid    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 16'h0000;
            busy        <= 1'b0;
`ifdef CMD_HOST_TIMEOUT_EN
            rsp_err_r   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r        <= cmd_op_t'(cmd_op);
                        addr_r      <= cmd_addr;
                        data_r      <= cmd_data;
                        opb_r       <= cmd_opb;
                        fun_r       <= cmd_fun;
                        frame_idx_r <= 2'd0;
                        tx_byte     <= frame_byte(cmd_op_t'(cmd_op), 2'd0, cmd_addr,
                                                  cmd_data, cmd_opb, cmd_fun);
                        tx_valid    <= 1'b1;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (last_frame_s) begin
                            tx_valid <= 1'b0;
                            rx_cnt_r <= 2'd0;
                            rx_lo_r  <= 8'h00;
                            if (op_r == OP_WRITE) begin
                                rsp_valid <= 1'b1;
                                rsp_data  <= 16'h0000;
`ifdef CMD_HOST_TIMEOUT_EN
                                rsp_err_r <= 1'b0;
`endif
                                state_r   <= DONE;
                            end else begin
                                state_r   <= WAIT_RSP;
                            end
                        end else begin
                            frame_idx_r <= frame_idx_r + 2'd1;
                            tx_byte     <= frame_byte(op_r, frame_idx_r + 2'd1, addr_r,
                                                      data_r, opb_r, fun_r);
                        end
                    end
                end
                WAIT_RSP: begin
                    if (rx_valid) begin
                        if (last_rx_s) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= (op_r == OP_READ) ? {8'h00, rx_byte} : {rx_byte, rx_lo_r};
`ifdef CMD_HOST_TIMEOUT_EN
                            rsp_err_r <= 1'b0;
`endif
                            state_r   <= DONE;
                        end else begin
                            rx_lo_r  <= rx_byte;
                            rx_cnt_r <= rx_cnt_r + 2'd1;
                        end
                    end
`ifdef CMD_HOST_TIMEOUT_EN
                    // Give up: report whatever arrived, missing bytes read as zero.
                    else if (wait_cnt_r == WAIT_LIMIT) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= (op_r == OP_READ) ? 16'h0000 : {8'h00, rx_lo_r};
                        rsp_err_r <= 1'b1;
                        state_r   <= DONE;
                    end
`endif
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    tx_valid  <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Self-checking bench for uart_cmd_host: directed vector table, random commands against a
// frame/response model, and hand-written reset, noise and (with CMD_HOST_TIMEOUT_EN) timeout cases.
module tb_uart_cmd_host;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [7:0]  cmd_opb;
    logic [3:0]  cmd_fun;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  fun;
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic [1:0]  mode;     // 0 always ready, 1 toggling ready, 2 random ready
        logic [15:0] exp_rsp;
    } vec_t;

    vec_t vecs[5];

    always #5 CLK = ~CLK;

    uart_cmd_host #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_opb(cmd_opb), .cmd_fun(cmd_fun),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected byte stream of a command, straight from the frame table.
    function automatic void build_frames(input logic [1:0] op, input logic [3:0] addr,
                                         input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] fun);
        exp_q = {};
        case (op)
            2'd0: exp_q = '{8'hAA, {4'h0, addr}, a};
            2'd1: exp_q = '{8'hBB, {4'h0, addr}};
            2'd2: exp_q = '{8'hCC, a, b, {4'h0, fun}};
            default: exp_q = '{8'hDD, {4'h0, fun}};
        endcase
    endfunction

    function automatic logic [15:0] model_rsp(input logic [1:0] op, input logic [7:0] r0,
                                              input logic [7:0] r1);
        if (op == 2'd0) return 16'h0000;
        else if (op == 2'd1) return {8'h00, r0};
        else return {r1, r0};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one command, check every frame handed off, feed the reply, check the response.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] fun, input logic [7:0] r0,
                          input logic [7:0] r1, input logic [1:0] mode, input bit noise,
                          input logic [15:0] exp_rsp);
        int got;
        int guard;
        int n_rsp;
        bit was_stall;
        logic [7:0] held;
        logic rdy;
        build_frames(op, addr, a, b, fun);
        n_rsp = (op == 2'd0) ? 0 : ((op == 2'd1) ? 1 : 2);
        check("cmd_ready_idle", {15'h0, cmd_ready}, 16'h0001);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = a; cmd_opb = b; cmd_fun = fun;
        tick();
        cmd_valid = 1'b0;
        check("tx_valid_first", {15'h0, tx_valid}, 16'h0001);
        check("busy_send", {15'h0, busy}, 16'h0001);
        got = 0; guard = 0; was_stall = 1'b0; held = 8'h00; rdy = 1'b0;
        while (got < exp_q.size() && guard < 200) begin
            if (mode == 2'd0) rdy = 1'b1;
            else if (mode == 2'd1) rdy = ~rdy;
            else rdy = 1'($urandom_range(0, 1));
            tx_ready = rdy;
            if (noise) begin
                rx_valid = 1'b1; rx_byte = 8'($urandom);
                cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_addr = 4'($urandom);
                cmd_data = 8'($urandom);
            end
            if (!tx_valid) begin
                check("tx_valid_during_send", {15'h0, tx_valid}, 16'h0001);
                guard = 200;
            end else begin
                if (was_stall) check("tx_byte_stable", {8'h00, tx_byte}, {8'h00, held});
                check("no_rsp_in_send", {15'h0, rsp_valid}, 16'h0000);
                if (rdy) begin
                    check($sformatf("frame%0d", got), {8'h00, tx_byte}, {8'h00, exp_q[got]});
                    got++;
                    was_stall = 1'b0;
                end else begin
                    was_stall = 1'b1;
                    held = tx_byte;
                end
                tick();
                guard++;
            end
        end
        rx_valid = 1'b0; cmd_valid = 1'b0; tx_ready = 1'b0;
        check("frames_sent", 16'(got), 16'(exp_q.size()));
        check("tx_valid_after", {15'h0, tx_valid}, 16'h0000);
        if (n_rsp > 0) begin
            check("busy_wait", {15'h0, busy}, 16'h0001);
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("no_rsp_before_rx", {15'h0, rsp_valid}, 16'h0000);
            end
            rx_byte = r0; rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            if (n_rsp == 2) begin
                check("no_rsp_after_first", {15'h0, rsp_valid}, 16'h0000);
                repeat ($urandom_range(0, 3)) tick();
                rx_byte = r1; rx_valid = 1'b1;
                tick();
                rx_valid = 1'b0;
            end
        end
        check("rsp_valid", {15'h0, rsp_valid}, 16'h0001);
        check("rsp_data", rsp_data, exp_rsp);
        check("rsp_err", {15'h0, rsp_err}, 16'h0000);
        tick();
        check("rsp_valid_pulse", {15'h0, rsp_valid}, 16'h0000);
        check("busy_idle", {15'h0, busy}, 16'h0000);
        check("rsp_data_hold", rsp_data, exp_rsp);
    endtask

    initial begin
        RST = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 4'h0; cmd_data = 8'h00;
        cmd_opb = 8'h00; cmd_fun = 4'h0; tx_ready = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0;
        vecs[0] = '{2'd0, 4'd3, 8'h5A, 8'h00, 4'd0, 8'h00, 8'h00, 2'd0, 16'h0000};
        vecs[1] = '{2'd1, 4'd2, 8'h00, 8'h00, 4'd0, 8'h81, 8'h00, 2'd0, 16'h0081};
        vecs[2] = '{2'd2, 4'd0, 8'h10, 8'h20, 4'd1, 8'h34, 8'h12, 2'd1, 16'h1234};
        vecs[3] = '{2'd3, 4'd0, 8'h00, 8'h00, 4'd9, 8'hEF, 8'h01, 2'd1, 16'h01EF};
        vecs[4] = '{2'd0, 4'hF, 8'hFF, 8'h00, 4'd0, 8'h00, 8'h00, 2'd2, 16'h0000};
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_cmd_ready", {15'h0, cmd_ready}, 16'h0001);
        check("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
        check("rst_tx_byte", {8'h00, tx_byte}, 16'h0000);
        check("rst_rsp_valid", {15'h0, rsp_valid}, 16'h0000);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_rsp_err", {15'h0, rsp_err}, 16'h0000);
        check("rst_busy", {15'h0, busy}, 16'h0000);

        for (int i = 0; i < 5; i++)
            do_cmd(vecs[i].op, vecs[i].addr, vecs[i].a, vecs[i].b, vecs[i].fun,
                   vecs[i].r0, vecs[i].r1, vecs[i].mode, 1'b0, vecs[i].exp_rsp);

        // rx pulses while idle must be ignored
        for (int i = 0; i < 3; i++) begin
            rx_byte = 8'(8'h40 + i); rx_valid = 1'b1;
            tick();
            check("idle_rx_busy", {15'h0, busy}, 16'h0000);
            check("idle_rx_rsp", {15'h0, rsp_valid}, 16'h0000);
        end
        rx_valid = 1'b0;
        tick();
        do_cmd(2'd1, 4'd7, 8'h00, 8'h00, 4'd0, 8'h5C, 8'h00, 2'd1, 1'b1, 16'h005C);
        do_cmd(2'd2, 4'd1, 8'hA5, 8'h3C, 4'd6, 8'h11, 8'h22, 2'd2, 1'b1, 16'h2211);

        // Reset in the middle of an ALU-op frame
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 8'h66; cmd_opb = 8'h77; cmd_fun = 4'd3;
        tick();
        cmd_valid = 1'b0; tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("mid_frame1", {8'h00, tx_byte}, 16'h0066);
        RST = 1'b1;
        #1;
        check("abort_tx_valid", {15'h0, tx_valid}, 16'h0000);
        check("abort_busy", {15'h0, busy}, 16'h0000);
        check("abort_rsp_valid", {15'h0, rsp_valid}, 16'h0000);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_byte = 8'(8'h90 + i); rx_valid = (i < 2);
            tick();
            check("abort_no_rsp", {15'h0, rsp_valid}, 16'h0000);
            check("abort_idle", {15'h0, cmd_ready}, 16'h0001);
        end
        rx_valid = 1'b0;
        do_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'd2, 8'h0D, 8'hF0, 2'd0, 1'b0, 16'hF00D);

        // Random commands against the model
        for (int i = 0; i < 25; i++) begin
            logic [1:0] op;
            logic [7:0] r0;
            logic [7:0] r1;
            op = 2'($urandom);
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            do_cmd(op, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), r0, r1,
                   2'd2, 1'($urandom_range(0, 1)), model_rsp(op, r0, r1));
        end

`ifdef CMD_HOST_TIMEOUT_EN
        begin
            int cycles;
            cmd_valid = 1'b1; cmd_op = 2'd3; cmd_fun = 4'd4;
            tick();
            cmd_valid = 1'b0; tx_ready = 1'b1;
            tick();
            tick();
            tx_ready = 1'b0;
            rx_byte = 8'h7F; rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            cycles = 1;
            while (!rsp_valid && cycles < 100) begin
                tick();
                cycles++;
            end
            check("timeout_cycles", 16'(cycles), 16'd16);
            check("timeout_err", {15'h0, rsp_err}, 16'h0001);
            check("timeout_data", rsp_data, 16'h007F);
            tick();
            check("timeout_idle", {15'h0, cmd_ready}, 16'h0001);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_host.md
UART_CMD_HOST -- requirements
Module: uart_cmd_host

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 4096, response-wait limit in CLK cycles (used only with the timeout feature).
REQ-002 SHALL have port: CLK  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: RST  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  in  1  command request.
REQ-005 SHALL have port: cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-006 SHALL have port: cmd_op  in  2  00 RF write, 01 RF read, 10 ALU with operands, 11 ALU no operands.
REQ-007 SHALL have port: cmd_addr  in  4  register address.
REQ-008 SHALL have port: cmd_data  in  8  write data or operand A.
REQ-009 SHALL have port: cmd_opb  in  8  operand B.
REQ-010 SHALL have port: cmd_fun  in  4  ALU function.
REQ-011 SHALL have ports: tx_byte  out  8; tx_valid  out  1; tx_ready  in  1  byte stream to UART transmitter.
REQ-012 SHALL have ports: rx_byte  in  8; rx_valid  in  1  single-cycle byte pulse from UART receiver.
REQ-013 SHALL have ports: rsp_valid  out  1 pulse; rsp_data  out  16; rsp_err  out  1; busy  out  1.

Function
REQ-014 SHALL use FSM states IDLE, SEND, WAIT_RSP, DONE; cmd_ready=1 only in IDLE; busy=1 outside IDLE.
REQ-015 SHALL, on acceptance, register all cmd_* fields and enter SEND; tx_valid asserts the next cycle with frame 0.
REQ-016 SHALL emit frames: write AA,{4'h0,addr},data; read BB,{4'h0,addr}; ALU-op CC,A,B,{4'h0,fun}; ALU-nop DD,{4'h0,fun}.
REQ-017 SHALL advance one frame per tx_valid&&tx_ready cycle; tx_byte held stable while tx_valid&&!tx_ready.
REQ-018 SHALL, after write's last frame is handed off, go to DONE: rsp_valid=1 one cycle, rsp_data=0, rsp_err=0.
REQ-019 SHALL, after read's last frame, enter WAIT_RSP, collect 1 byte; rsp_data={8'h00,byte}.
REQ-020 SHALL, for ALU commands, collect 2 bytes, LSB first; rsp_data={second,first}.
REQ-021 SHALL assert rsp_valid the cycle after the final rx_valid, then return to IDLE the following cycle.
REQ-022 SHALL ignore rx_valid outside WAIT_RSP (no capture, no state change).
REQ-023 SHALL ignore cmd_valid while not in IDLE; rsp_data/rsp_err hold last value between responses.

Reset
REQ-024 SHALL, on RST high at any time (including mid-frame or WAIT_RSP), enter IDLE immediately; no rsp_valid for the aborted command.
REQ-025 SHALL reset outputs: cmd_ready=1 after release, tx_valid=0, tx_byte=00, rsp_valid=0, rsp_data=0000, rsp_err=0, busy=0.

Configuration
REQ-026 SHALL, with CMD_HOST_TIMEOUT_EN defined, count cycles in WAIT_RSP; at TIMEOUT_CYCLES without completion go to DONE with rsp_err=1, rsp_data=partial bytes captured (missing bytes 0); counter clears on each state entry.
REQ-027 SHALL, without CMD_HOST_TIMEOUT_EN, wait indefinitely in WAIT_RSP; rsp_err tied 0; no counter logic.

Structure
REQ-028 SHALL place opcodes (AA,BB,CC,DD), cmd_op encodings, state enum and per-op frame/response counts in shared package uart_cmd_pkg.
REQ-029 SHALL be a single module; no sub-module required (timeout counter inline under the macro).

Verification
REQ-030 SHALL cover: write addr=3 data=5A, tx_ready=1 -> bytes AA,03,5A on consecutive cycles, rsp_valid with rsp_data=0000.
REQ-031 SHALL cover: read addr=2, rx pulse 0x81 -> BB,02 sent; rsp_data=0081 one cycle after rx pulse.
REQ-032 SHALL cover: ALU-op A=10 B=20 fun=1, tx_ready toggling -> CC,10,20,01 with tx_byte stable during stalls; rx 34 then 12 -> rsp_data=1234.
REQ-033 SHALL cover: rx_valid pulses in IDLE and SEND, cmd_valid during SEND -> ignored, frames/response unaffected.
REQ-034 SHALL cover: RST asserted after frame 1 of ALU-op -> tx_valid=0 immediately, no rsp_valid; next command runs normally.
REQ-035 SHALL cover (CMD_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=16): ALU-nop, one rx byte 0x7F only -> rsp_err=1, rsp_data=007F after 16 cycles.
